fetch_unit: RTL

//  Front-end fetch stage directly upstream of the decoder in the OoO RISC-V core.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared widths and the fetch buffer entry type for the front end
// Rev 1.0
// ============================================================================
package riscv_pkg;

  localparam int PC_W        = 9;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // Clears the byte-offset bits so every PC points at a whole instruction.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~(PC_W'(INSTR_BYTES - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous FIFO with flush; flush overrides push and pop
// Rev 1.0
// ============================================================================
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output T                         data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          w_push;
  logic          w_pop;

  assign w_push = push_i && !flush_i;
  assign w_pop  = pop_i && !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH[PW:0]);
  assign count_o = count_q;
  assign data_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && full_o && !w_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_pop && empty_o));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : sequential PC generator with credit-limited 1-cycle imem
//              fetch, buffered decoder handshake and redirect flush
// Rev 1.0
// ============================================================================
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 9'h000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               o_imem_req,
  output logic [PC_W-1:0]    o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_redirect_valid,
  input  logic [PC_W-1:0]    i_redirect_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [PC_W-1:0]    o_pc,
  input  logic               i_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_credit_used;
  logic            w_empty, w_full;
  logic            w_req, w_push, w_pop;
  fetch_entry_t    w_push_entry, w_head;

  // Buffered plus in-flight words may never exceed the FIFO, so a push always has room.
  assign w_credit_used = w_count + CW'(inflight_q);
  assign w_req  = !reset && !i_redirect_valid && (w_credit_used < DEPTH[CW-1:0]);
  assign w_push = inflight_q && !i_redirect_valid;
  assign w_pop  = o_valid && i_ready;

  assign w_push_entry.instr = i_imem_rdata;
  assign w_push_entry.pc    = req_pc_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    if (i_redirect_valid) begin
      pc_d       = align_pc(i_redirect_pc);
      inflight_d = 1'b0;
    end else begin
      inflight_d = w_req;
      if (w_req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + PC_W'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .flush_i (i_redirect_valid),
    .data_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  assign o_imem_req    = w_req;
  assign o_imem_addr   = pc_q;
  assign o_valid       = !w_empty && !i_redirect_valid;
  assign o_instruction = w_head.instr;
  assign o_pc          = w_head.pc;

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    w_credit_used <= DEPTH[CW-1:0]);
  a_push_has_room: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_full && !w_pop));
  a_pc_aligned: assert property (@(posedge clk) disable iff (reset)
    o_valid |-> (o_pc[1:0] == 2'b00));

endmodule
`default_nettype wire
